// File: rtl/mdc_stage_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdc_stage_ctrl_pkg
// Description : Shared constants, state encoding and delay helpers for the
//               MDC FFT stage sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mdc_stage_ctrl_pkg;

    localparam int DEF_LOG2N = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    // Delay-line depth of a stage; the last stage has no delay line.
    function automatic int stage_dly(input int log2n, input int stage);
        return (stage < log2n - 1) ? (1 << (log2n - 2 - stage)) : 0;
    endfunction

    function automatic int tw_mask(input int log2n, input int stage);
        return (1 << (log2n - 1 - stage)) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdc_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mdc_stage_ctrl_if
// Description : Input handshake and stage-control bundle of the MDC stage
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mdc_stage_ctrl_if
    import mdc_stage_ctrl_pkg::*;
#(
    parameter int LOG2N = DEF_LOG2N
) ();

    logic             in_valid;
    logic             in_sof;
    logic             in_ready;
    logic             shift_en;
    logic             sw_sel;
    logic             bf_mode;
    logic [LOG2N-2:0] tw_addr;
    logic             out_valid;
    logic             out_sof;
    logic             err;

    modport master (
        output in_valid, in_sof,
        input  in_ready, shift_en, sw_sel, bf_mode, tw_addr, out_valid, out_sof, err
    );

    modport slave (
        input  in_valid, in_sof,
        output in_ready, shift_en, sw_sel, bf_mode, tw_addr, out_valid, out_sof, err
    );

endinterface
`default_nettype wire

// File: rtl/mdc_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdc_stage_ctrl
// Description : Sequencer for one radix-2 MDC FFT stage: fill, back-to-back
//               frames and tail flush, plus twiddle address and output tags.
// Revision    : 1.0 - initial release
// ============================================================================
module mdc_stage_ctrl
    import mdc_stage_ctrl_pkg::*;
#(
    parameter int LOG2N = DEF_LOG2N,
    parameter int STAGE = 0
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    mdc_stage_ctrl_if.slave  bus
);

    localparam int                 CNT_W       = LOG2N - 1;
    localparam int                 C_DLY       = stage_dly(LOG2N, STAGE);
    localparam logic [CNT_W-1:0]   C_DLY_LAST  = CNT_W'((C_DLY > 0) ? C_DLY - 1 : 0);
    localparam logic [CNT_W-1:0]   C_TW_MASK   = CNT_W'(tw_mask(LOG2N, STAGE));
    localparam state_e             C_END_STATE = (C_DLY > 0) ? ST_FLUSH : ST_IDLE;

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] in_cnt_q,   in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q,  out_cnt_d;
    logic [CNT_W-1:0] fl_cnt_q,   fl_cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             err_q,      err_d;

    logic             w_accept;
    logic             w_shift_en;
    logic             w_out_valid;
    logic             w_boundary;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            fl_cnt_q   <= '0;
            in_ready_q <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            fl_cnt_q   <= fl_cnt_d;
            in_ready_q <= in_ready_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        // rst_n gating keeps the combinational outputs quiet while reset is held
        w_accept    = bus.in_valid & in_ready_q & rst_n;
        w_boundary  = (state_q == ST_RUN) && (in_cnt_q == '0);
        state_d     = state_q;
        fl_cnt_d    = fl_cnt_q;
        err_d       = 1'b0;
        w_shift_en  = 1'b0;
        w_out_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (bus.in_sof) begin
                        w_shift_en  = 1'b1;
                        w_out_valid = (C_DLY == 0);
                        state_d     = (C_DLY <= 1) ? ST_RUN : ST_FILL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_FILL, ST_RUN: begin
                if (w_boundary) begin
                    // No stall allowed between frames: silence ends the stream
                    if (w_accept && bus.in_sof) begin
                        w_shift_en  = 1'b1;
                        w_out_valid = 1'b1;
                    end else begin
                        err_d   = w_accept;
                        state_d = C_END_STATE;
                    end
                end else if (w_accept) begin
                    w_shift_en  = 1'b1;
                    w_out_valid = (state_q == ST_RUN);
                    err_d       = bus.in_sof;
                    if (state_q == ST_FILL && in_cnt_q == C_DLY_LAST) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_FLUSH: begin
                w_shift_en  = 1'b1;
                w_out_valid = 1'b1;
                if (fl_cnt_q == C_DLY_LAST) begin
                    fl_cnt_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    fl_cnt_d = fl_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_cnt_d = w_shift_en ? in_cnt_q + 1'b1 : in_cnt_q;
        if (state_q == ST_FLUSH && state_d == ST_IDLE) begin
            in_cnt_d = '0;
        end
        out_cnt_d  = w_out_valid ? out_cnt_q + 1'b1 : out_cnt_q;
        in_ready_d = (state_d != ST_FLUSH);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.err       = err_q;
    assign bus.shift_en  = w_shift_en;
    assign bus.out_valid = w_out_valid;
    assign bus.out_sof   = w_out_valid & (out_cnt_q == '0);
    assign bus.bf_mode   = ~w_out_valid;
    assign bus.tw_addr   = (out_cnt_q & C_TW_MASK) << STAGE;

    generate
        if (C_DLY > 0) begin : g_sw_sel
            assign bus.sw_sel = w_shift_en & in_cnt_q[LOG2N-2-STAGE];
        end else begin : g_sw_sel_none
            assign bus.sw_sel = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire
